cpu_trace_buffer: RTL
=====================

# cpu_trace_buffer

Parametrised execution-trace capture buffer for the single-cycle CPU bench. Each enabled cycle it samples the CPU's observable outputs (pc, fetched instruction, ALU result, control flags) into a DEPTH-entry circular buffer. Three capture modes are supported: continuous, stop-when-full, and PC-triggered with pre/post window. The captured trace is drained oldest-first through a valid/ready port.

## Interface
- ADDR_W, 32: pc width.
- INSTR_W, 32: instruction width.
- DATA_W, 32: result width.
- DEPTH, 16: entries; power of two, ≥4.
- CNT_W, $clog2(DEPTH)+1: count width (derived).
- ENTRY_W, ADDR_W+INSTR_W+DATA_W+9: entry width (derived).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  CPU advanced this cycle; sample qualifier.
- pc  in  ADDR_W  program counter.
- instr_out  in  INSTR_W  fetched instruction.
- result  in  DATA_W  ALU result.
- ctrl  in  9  {regDst,jump,branch,memRead,memToReg,memWrite,aluSrc,regWrite,aluZero}, MSB first.
- mode  in  2  00 continuous, 01 stop-when-full, 10 pc-trigger, 11 reserved (treated as 00); sampled at arm.
- arm  in  1  one-cycle pulse: clear buffer, start capture.
- stop  in  1  one-cycle pulse: end capture (any mode).
- trig_pc  in  ADDR_W  trigger address (mode 10); sampled at arm.
- post_len  in  CNT_W  entries after trigger entry, ≤DEPTH-1; sampled at arm.
- rd_valid  out  1  entry available.
- rd_ready  in  1  consumer accepts.
- rd_data  out  ENTRY_W  {pc,instr_out,result,ctrl} of oldest entry.
- count  out  CNT_W  stored entries, 0..DEPTH.
- overflow  out  1  sticky: an entry was overwritten since arm.
- triggered  out  1  trigger seen since arm.
- busy  out  1  state is CAPTURE or POST.

## Operation
- States: IDLE, CAPTURE, POST, DONE. Reset → IDLE.
- IDLE/DONE + arm → CAPTURE. Arm clears wr_ptr, rd_ptr, count, overflow, and triggered, and latches mode, trig_pc, and post_len.
- Arm in CAPTURE/POST restarts the capture (same clear); arm wins over a simultaneous stop.
- CAPTURE, enable=1: write the entry at wr_ptr, then wr_ptr++ (mod DEPTH).
  - If count<DEPTH: count++.
  - Else, mode 00/10: overwrite the oldest entry, rd_ptr++, overflow←1. Mode 01 never reaches this case.
- Mode 01: the write that makes count==DEPTH → DONE the following cycle. No further writes.
- Mode 10: enabled sample with pc==trig_pc while in CAPTURE is written, triggered←1, and the state goes to POST with post_cnt←post_len.
  - If post_len==0 → DONE directly.
- POST: each enabled write decrements post_cnt (same wrap/overwrite rule). The write taking post_cnt to 0 → DONE.
- stop in CAPTURE/POST → DONE. The sample written in the same cycle is kept.
- Readout is legal only in IDLE/DONE.
  - rd_valid = (count≠0) && state∈{IDLE,DONE}.
  - rd_data = mem[rd_ptr], combinational.
  - valid&&ready: rd_ptr++, count--.
- rd_ready is ignored while busy. No pops occur during capture.
- A new arm discards any unread entries.

## Timing
- Reset (async assert, sync-released by the bench): state IDLE, rd_valid 0, count 0, overflow 0, triggered 0, busy 0, rd_data 0 (memory contents undefined; rd_data masked to 0 while count==0).
- Capture latency: a sample on edge N appears in count after edge N. It is readable in the first cycle after entering DONE.
- State transitions take effect on the edge where the condition is sampled. busy drops the cycle after the last write.
- Pop throughput: one entry per cycle with rd_ready held high. rd_valid drops the cycle after count reaches 0.
- Pointers wrap DEPTH-1→0. count saturates at DEPTH. Reads are always oldest-first after wrap.
- enable=0 cycles store nothing and do not advance post_cnt.

## Test plan
- Reset mid-capture (after 5 writes) → all outputs at reset values; state IDLE; rd_valid 0.
- Mode 01, DEPTH=16, 20 enabled cycles pc=0,4,…,76 → count 16, DONE, overflow 0; drain reads pc 0..60 in order.
- Mode 00, 20 enabled cycles pc=0..76, then stop → count 16, overflow 1; drain reads pc 16..76.
- Mode 10, trig_pc=40, post_len=3, pc=0,4,… → triggered 1; DONE after the pc=52 write; last entry pc=52; entry 4 back is pc=40.
- Mode 10, trig_pc never hit, stop after 8 writes → triggered 0, count 8; drain works with rd_ready toggling 1,0,1,… and each entry is read once.
- arm and stop in the same cycle during CAPTURE → buffer cleared, state CAPTURE; a subsequent sample is counted as 1.

Source files
------------

// File: rtl/cpu_trace_buffer_if.sv
// cpu_trace_buffer_if: capture-side and readout-side signals of the trace buffer
interface cpu_trace_buffer_if #(
    parameter int ADDR_W  = 32,
    parameter int INSTR_W = 32,
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 16,
    parameter int CNT_W   = $clog2(DEPTH) + 1,
    parameter int ENTRY_W = ADDR_W + INSTR_W + DATA_W + 9
);
    logic               enable;
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr_out;
    logic [DATA_W-1:0]  result;
    logic [8:0]         ctrl;
    logic [1:0]         mode;
    logic               arm;
    logic               stop;
    logic [ADDR_W-1:0]  trig_pc;
    logic [CNT_W-1:0]   post_len;
    logic               rd_valid;
    logic               rd_ready;
    logic [ENTRY_W-1:0] rd_data;
    logic [CNT_W-1:0]   count;
    logic               overflow;
    logic               triggered;
    logic               busy;

    modport master (
        output enable, pc, instr_out, result, ctrl, mode, arm, stop, trig_pc, post_len, rd_ready,
        input  rd_valid, rd_data, count, overflow, triggered, busy
    );

    modport slave (
        input  enable, pc, instr_out, result, ctrl, mode, arm, stop, trig_pc, post_len, rd_ready,
        output rd_valid, rd_data, count, overflow, triggered, busy
    );
endinterface

// File: rtl/cpu_trace_buffer.sv
// cpu_trace_buffer: circular execution-trace capture with continuous, stop-when-full and pc-trigger modes
module cpu_trace_buffer #(
    parameter int ADDR_W  = 32,
    parameter int INSTR_W = 32,
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 16,
    parameter int CNT_W   = $clog2(DEPTH) + 1,
    parameter int ENTRY_W = ADDR_W + INSTR_W + DATA_W + 9
) (
    input logic clk,
    input logic rst_n,
    cpu_trace_buffer_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, CAPTURE, POST, DONE} state_t;

    state_t             state;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   post_cnt;
    logic [CNT_W-1:0]   post_len_q;
    logic [ADDR_W-1:0]  trig_q;
    logic [1:0]         mode_q;
    logic               overflow;
    logic               triggered;
    logic [ENTRY_W-1:0] mem [DEPTH];

    logic busy;
    logic full;
    logic wr_en;
    logic pop;

    assign busy  = state == CAPTURE || state == POST;
    assign full  = cnt == CNT_W'(DEPTH);
    assign wr_en = busy && bus.enable && !bus.arm;
    assign pop   = !busy && cnt != '0 && bus.rd_ready && !bus.arm;

    assign bus.busy      = busy;
    assign bus.count     = cnt;
    assign bus.overflow  = overflow;
    assign bus.triggered = triggered;
    assign bus.rd_valid  = !busy && cnt != '0;
    assign bus.rd_data   = cnt == '0 ? '0 : mem[rd_ptr];

    // Trace storage; contents are don't-care until written, so no reset
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= {bus.pc, bus.instr_out, bus.result, bus.ctrl};
    end

    // Capture FSM with pointer/count bookkeeping; arm overrides everything else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            cnt        <= '0;
            post_cnt   <= '0;
            post_len_q <= '0;
            trig_q     <= '0;
            mode_q     <= 2'b00;
            overflow   <= 1'b0;
            triggered  <= 1'b0;
        end else if (bus.arm) begin
            state      <= CAPTURE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            cnt        <= '0;
            post_cnt   <= '0;
            post_len_q <= bus.post_len;
            trig_q     <= bus.trig_pc;
            mode_q     <= bus.mode == 2'b11 ? 2'b00 : bus.mode;
            overflow   <= 1'b0;
            triggered  <= 1'b0;
        end else if (busy) begin
            if (bus.enable) begin
                wr_ptr <= wr_ptr + 1'b1;
                if (full) begin
                    rd_ptr   <= rd_ptr + 1'b1;
                    overflow <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                if (state == POST) begin
                    post_cnt <= post_cnt - 1'b1;
                    if (post_cnt == CNT_W'(1)) state <= DONE;
                end else if (mode_q == 2'b10 && bus.pc == trig_q) begin
                    triggered <= 1'b1;
                    post_cnt  <= post_len_q;
                    state     <= post_len_q == '0 ? DONE : POST;
                end else if (mode_q == 2'b01 && cnt == CNT_W'(DEPTH - 1)) begin
                    state <= DONE;
                end
            end
            if (bus.stop) state <= DONE;
        end else if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
            cnt    <= cnt - 1'b1;
        end
    end
endmodule
